dodawanie_reg: RTL and testbench



---
 rtl/dodawanie_reg_if.sv | 23 ++
 rtl/dodawanie_reg.sv | 81 ++++++++
 tb/tb_dodawanie_reg.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/dodawanie_reg_if.sv
// Operand/result bundle for the registered adder: operand pair in, sum and flags out.
interface dodawanie_reg_if #(
    parameter int unsigned WIDTH = 32
);
    logic             i_valid;
    logic [WIDTH-1:0] i_argA;
    logic [WIDTH-1:0] i_argB;
    logic             o_valid;
    logic [WIDTH-1:0] o_result;
    logic             o_carry;
    logic             o_overflow;
    logic             o_zero;

    modport master (
        output i_valid, i_argA, i_argB,
        input  o_valid, o_result, o_carry, o_overflow, o_zero
    );

    modport slave (
        input  i_valid, i_argA, i_argB,
        output o_valid, o_result, o_carry, o_overflow, o_zero
    );
endinterface

// File: rtl/dodawanie_reg.sv
// Registered adder: 4-bit carry-lookahead groups rippled across WIDTH/4 groups,
// sum/carry/overflow/zero captured one cycle after a valid operand pair.
module dodawanie_reg #(
    parameter int unsigned WIDTH = 32
) (
    input logic            i_clk,
    input logic            i_rst_n,
    dodawanie_reg_if.slave bus
);
    localparam int unsigned NGRP = WIDTH / 4;
    localparam int unsigned MSB  = WIDTH - 1;

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;
    logic [NGRP-1:0]  grp_g;
    logic [NGRP-1:0]  grp_p;
    logic [NGRP:0]    grp_c;
    logic             ovf_c;
    logic             zero_c;

    logic             valid_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             overflow_q;
    logic             zero_q;

    assign gen      = bus.i_argA & bus.i_argB;
    assign prop     = bus.i_argA ^ bus.i_argB;
    assign grp_c[0] = 1'b0;

    // Per-group lookahead for the internal carries plus group generate/propagate.
    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        localparam int unsigned B = 4 * k;

        assign carry[B]   = grp_c[k];
        assign carry[B+1] = gen[B] | (prop[B] & grp_c[k]);
        assign carry[B+2] = gen[B+1] | (prop[B+1] & gen[B])
                          | (prop[B+1] & prop[B] & grp_c[k]);
        assign carry[B+3] = gen[B+2] | (prop[B+2] & gen[B+1])
                          | (prop[B+2] & prop[B+1] & gen[B])
                          | (prop[B+2] & prop[B+1] & prop[B] & grp_c[k]);

        assign grp_g[k] = gen[B+3] | (prop[B+3] & gen[B+2])
                        | (prop[B+3] & prop[B+2] & gen[B+1])
                        | (prop[B+3] & prop[B+2] & prop[B+1] & gen[B]);
        assign grp_p[k] = &prop[B+3:B];
        assign grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
    end

    assign carry[WIDTH] = grp_c[NGRP];
    assign sum          = prop ^ carry[WIDTH-1:0];
    assign ovf_c        = (bus.i_argA[MSB] == bus.i_argB[MSB]) && (sum[MSB] != bus.i_argA[MSB]);
    assign zero_c       = (sum == '0);

    // Result and flags load only on a valid pair; invalid cycles just drop o_valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q    <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            valid_q <= bus.i_valid;
            if (bus.i_valid) begin
                result_q   <= sum;
                carry_q    <= carry[WIDTH];
                overflow_q <= ovf_c;
                zero_q     <= zero_c;
            end
        end
    end

    assign bus.o_valid    = valid_q;
    assign bus.o_result   = result_q;
    assign bus.o_carry    = carry_q;
    assign bus.o_overflow = overflow_q;
    assign bus.o_zero     = zero_q;
endmodule

// File: tb/tb_dodawanie_reg.sv
// Bench for dodawanie_reg at WIDTH 4, 32 and 64 driven in lockstep, with a
// per-width scoreboard queue plus fixed expected values for the directed cases.
module tb_dodawanie_reg;
    typedef struct packed {
        logic        v;
        logic [63:0] r;
        logic        c;
        logic        o;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    exp_t q4[$];
    exp_t q32[$];
    exp_t q64[$];
    exp_t held4, held32, held64;

    always #5 clk = ~clk;

    dodawanie_reg_if #(.WIDTH(4))  b4 ();
    dodawanie_reg_if #(.WIDTH(32)) b32 ();
    dodawanie_reg_if #(.WIDTH(64)) b64 ();

    dodawanie_reg #(.WIDTH(4))  u4  (.i_clk(clk), .i_rst_n(rst_n), .bus(b4));
    dodawanie_reg #(.WIDTH(32)) u32 (.i_clk(clk), .i_rst_n(rst_n), .bus(b32));
    dodawanie_reg #(.WIDTH(64)) u64 (.i_clk(clk), .i_rst_n(rst_n), .bus(b64));

    // Behavioural reference: WIDTH+1-bit sum with hold on invalid cycles.
    function automatic exp_t model(input int w, input exp_t held, input logic vld,
                                   input logic [63:0] a, input logic [63:0] b);
        exp_t        e;
        logic [63:0] m;
        logic [64:0] s;
        e   = held;
        e.v = vld;
        if (vld) begin
            m   = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
            s   = {1'b0, a & m} + {1'b0, b & m};
            e.r = s[63:0] & m;
            e.c = s[w];
            e.z = (e.r == 64'd0);
            e.o = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
        end
        return e;
    endfunction

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cmp_set(input string tag, input exp_t e, input logic v, input logic [63:0] r,
                           input logic c, input logic o, input logic z);
        cmp({tag, " valid"},    64'(v), 64'(e.v));
        cmp({tag, " result"},   r,      e.r);
        cmp({tag, " carry"},    64'(c), 64'(e.c));
        cmp({tag, " overflow"}, 64'(o), 64'(e.o));
        cmp({tag, " zero"},     64'(z), 64'(e.z));
    endtask

    task automatic sb_check();
        if (q4.size() == 0 || q32.size() == 0 || q64.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: queue empty, observed none expected one entry");
        end else begin
            cmp_set("w4",  q4.pop_front(),  b4.o_valid,  64'(b4.o_result),
                    b4.o_carry,  b4.o_overflow,  b4.o_zero);
            cmp_set("w32", q32.pop_front(), b32.o_valid, 64'(b32.o_result),
                    b32.o_carry, b32.o_overflow, b32.o_zero);
            cmp_set("w64", q64.pop_front(), b64.o_valid, b64.o_result,
                    b64.o_carry, b64.o_overflow, b64.o_zero);
        end
    endtask

    task automatic drive(input logic vld, input logic [63:0] a, input logic [63:0] b);
        b4.i_valid  = vld;  b4.i_argA  = a[3:0];  b4.i_argB  = b[3:0];
        b32.i_valid = vld;  b32.i_argA = a[31:0]; b32.i_argB = b[31:0];
        b64.i_valid = vld;  b64.i_argA = a;       b64.i_argB = b;
    endtask

    // Drive at the falling edge, let one rising edge capture, check at the next falling edge.
    task automatic step(input logic vld, input logic [63:0] a, input logic [63:0] b);
        drive(vld, a, b);
        held4  = model(4,  held4,  vld, a, b);
        held32 = model(32, held32, vld, a, b);
        held64 = model(64, held64, vld, a, b);
        q4.push_back(held4);
        q32.push_back(held32);
        q64.push_back(held64);
        @(negedge clk);
        sb_check();
    endtask

    task automatic check_all_zero(input string tag);
        exp_t z;
        z = '0;
        cmp_set({tag, " w4"},  z, b4.o_valid,  64'(b4.o_result),  b4.o_carry,  b4.o_overflow,  b4.o_zero);
        cmp_set({tag, " w32"}, z, b32.o_valid, 64'(b32.o_result), b32.o_carry, b32.o_overflow, b32.o_zero);
        cmp_set({tag, " w64"}, z, b64.o_valid, b64.o_result,      b64.o_carry, b64.o_overflow, b64.o_zero);
    endtask

    task automatic cmp32(input string tag, input logic v, input logic [31:0] r,
                         input logic c, input logic o, input logic z);
        cmp({tag, " valid"},    64'(b32.o_valid),    64'(v));
        cmp({tag, " result"},   64'(b32.o_result),   64'(r));
        cmp({tag, " carry"},    64'(b32.o_carry),    64'(c));
        cmp({tag, " overflow"}, 64'(b32.o_overflow), 64'(o));
        cmp({tag, " zero"},     64'(b32.o_zero),     64'(z));
    endtask

    initial begin
        held4  = '0;
        held32 = '0;
        held64 = '0;

        // Reset held low with live operands: nothing may be captured.
        rst_n = 1'b0;
        drive(1'b1, 64'hDEAD_BEEF_1234_5678, 64'h0F0F_0F0F_F0F0_F0F0);
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        step(1'b1, 64'hFFFF_FFFF, 64'h1);
        cmp32("wrap", 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        step(1'b1, 64'h7FFF_FFFF, 64'h1);
        cmp32("ovf_pos", 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        step(1'b1, 64'h8000_0000, 64'h8000_0000);
        cmp32("ovf_neg", 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        step(1'b1, 64'h1234_5678, 64'h1111_1111);
        cmp32("grp_chain", 1'b1, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'hF, 64'h1);
        cmp32("grp_carry", 1'b1, 32'h0000_0010, 1'b0, 1'b0, 1'b0);

        step(1'b1, 64'd5, 64'd7);
        cmp32("cap_5_7", 1'b1, 32'd12, 1'b0, 1'b0, 1'b0);
        step(1'b0, 64'd1, 64'd1);
        cmp32("hold", 1'b0, 32'd12, 1'b0, 1'b0, 1'b0);
        step(1'b0, 64'bx, 64'bx);
        cmp32("hold_x", 1'b0, 32'd12, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'd1, 64'd2);
        cmp32("b2b_1", 1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'd3, 64'd4);
        cmp32("b2b_2", 1'b1, 32'd7, 1'b0, 1'b0, 1'b0);

        // Reset asserted between edges clears outputs without a clock edge.
        step(1'b1, 64'd9, 64'd9);
        cmp32("pre_rst", 1'b1, 32'd18, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'd100, 64'd100);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        held4  = '0;
        held32 = '0;
        held64 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 64'd6, 64'd6);
        cmp32("post_rst", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            step(1'b1, {$urandom, $urandom}, {$urandom, $urandom});
        end
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
        step(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
        step(1'b0, 64'd0, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
